// File: rtl/sop_sweep_ctrl.sv
// rtl/sop_sweep_ctrl.sv - exhaustive truth-table sweep and compare controller for a combinational function.
// Optional: define SOP_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module sop_sweep_ctrl #(
    parameter int N_IN   = 8,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected_tt,
    output logic [N_IN-1:0]      vec,
    input  logic                 func_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail_vec,
    output logic                 first_fail_valid
);

    localparam logic [N_IN-1:0] LAST_VEC   = '1;
    localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    state_t        state;
    logic [3:0]    settle_cnt;
    logic          mismatch;
    logic [N_IN:0] err_next;
    logic          finish_sweep;

    assign mismatch = (func_out != expected_tt[vec]);
    // err_count is one bit wider than vec, so counting all 2^N_IN vectors cannot wrap
    assign err_next = err_count + (N_IN+1)'(mismatch);

`ifdef SOP_SWEEP_STOP_ON_FAIL_EN
    assign finish_sweep = mismatch || (vec == LAST_VEC);
`else
    assign finish_sweep = (vec == LAST_VEC);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            settle_cnt       <= 4'd0;
            vec              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                // partial err_count and first_fail_* are left visible to the host
                state      <= IDLE;
                settle_cnt <= 4'd0;
                busy       <= 1'b0;
                pass       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state            <= DRIVE;
                            vec              <= '0;
                            busy             <= 1'b1;
                            pass             <= 1'b0;
                            err_count        <= '0;
                            first_fail_vec   <= '0;
                            first_fail_valid <= 1'b0;
                        end
                    end
                    DRIVE: begin
                        if (SETTLE == 0) begin
                            state <= SAMPLE;
                        end else begin
                            settle_cnt <= SETTLE_CNT;
                            state      <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (settle_cnt <= 4'd1) begin
                            settle_cnt <= 4'd0;
                            state      <= SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end
                    SAMPLE: begin
                        err_count <= err_next;
                        if (mismatch && !first_fail_valid) begin
                            first_fail_vec   <= vec;
                            first_fail_valid <= 1'b1;
                        end
                        if (finish_sweep) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (err_next == '0);
                        end else begin
                            vec   <= vec + 1'b1;
                            state <= DRIVE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// tb/tb_sop_sweep_ctrl.sv - randomized self-checking bench for sop_sweep_ctrl at SETTLE 0 and 3.
module tb_sop_sweep_ctrl;

    localparam int N  = 8;
    localparam int NV = 256;
`ifdef SOP_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [NV-1:0] tt, fmask;
    logic [N-1:0]  vec0, vec3, ffv0, ffv3;
    logic [N:0]    err0, err3;
    logic busy0, busy3, done0, done3, pass0, pass3, ffval0, ffval3;
    logic fo0, fo3;

    int nchk = 0;
    int nfail = 0;

    // function under test: the expected table with selected vectors inverted
    assign fo0 = tt[vec0] ^ fmask[vec0];
    assign fo3 = tt[vec3] ^ fmask[vec3];

    always #5 clk = ~clk;

    sop_sweep_ctrl #(.N_IN(N), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected_tt(tt),
        .vec(vec0), .func_out(fo0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail_vec(ffv0), .first_fail_valid(ffval0)
    );

    sop_sweep_ctrl #(.N_IN(N), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected_tt(tt),
        .vec(vec3), .func_out(fo3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_fail_vec(ffv3), .first_fail_valid(ffval3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int n_faults();
        int n = 0;
        for (int i = 0; i < NV; i++) n += int'(fmask[i]);
        return n;
    endfunction

    function automatic int first_fault();
        for (int i = 0; i < NV; i++) if (fmask[i]) return i;
        return -1;
    endfunction

    function automatic int exp_err();
        if (n_faults() == 0) return 0;
        return STOP ? 1 : n_faults();
    endfunction

    function automatic int last_vec();
        return (STOP && first_fault() >= 0) ? first_fault() : NV - 1;
    endfunction

    function automatic int exp_vec(input int k, input int s);
        int v = k / (2 + s);
        return (v > last_vec()) ? last_vec() : v;
    endfunction

    task automatic run_sweep(input string tag);
        int d0n = 0, d3n = 0, d0k = -1, d3k = -1, bad = 0;
        int dk0 = 2 * (last_vec() + 1);
        int dk3 = 5 * (last_vec() + 1);
        int ff = first_fault();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, "_busy_at_start"}, {busy0, busy3}, 2'b11);
        for (int k = 1; k <= 1300; k++) begin
            @(negedge clk);
            if (done0) begin d0n++; d0k = k; end
            if (done3) begin d3n++; d3k = k; end
            if (vec0 !== N'(exp_vec(k, 0))) bad++;
            if (vec3 !== N'(exp_vec(k, 3))) bad++;
            if (busy0 !== (k < dk0)) bad++;
            if (busy3 !== (k < dk3)) bad++;
        end
        chk({tag, "_vec_busy_trace"}, bad, 0);
        chk({tag, "_done0_pulses"}, d0n, 1);
        chk({tag, "_done0_time"}, d0k, dk0);
        chk({tag, "_done3_pulses"}, d3n, 1);
        chk({tag, "_done3_time"}, d3k, dk3);
        chk({tag, "_err0"}, err0, exp_err());
        chk({tag, "_err3"}, err3, exp_err());
        chk({tag, "_pass"}, {pass0, pass3}, (ff < 0) ? 2'b11 : 2'b00);
        chk({tag, "_ffvalid"}, {ffval0, ffval3}, (ff < 0) ? 2'b00 : 2'b11);
        if (ff >= 0) begin
            chk({tag, "_ffv0"}, ffv0, ff);
            chk({tag, "_ffv3"}, ffv3, ff);
        end
    endtask

    initial begin
        int a, b, c, dn;
        rst = 1'b1; start = 1'b0; abort = 1'b0; fmask = '0; tt = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", {vec0, busy0, done0, pass0, err0, ffv0, ffval0}, 0);
        chk("reset_outputs3", {vec3, busy3, done3, pass3, err3, ffv3, ffval3}, 0);

        for (int i = 0; i < 8; i++) tt[i*32 +: 32] = $urandom();
        fmask = '0;
        run_sweep("match");

        for (int i = 0; i < 8; i++) tt[i*32 +: 32] = $urandom();
        fmask = '0; fmask[8'h5A] = 1'b1;
        run_sweep("single");

        fmask = '1;
        run_sweep("compl");

        for (int i = 0; i < 8; i++) tt[i*32 +: 32] = $urandom();
        fmask = '0;
        for (int i = 0; i < 6; i++) fmask[$urandom_range(NV - 1, 0)] = 1'b1;
        run_sweep("rand");

        // start while busy at 0x10, abort at 0x80 after three mismatches
        a = $urandom_range(16'h30, 16'h11);
        b = $urandom_range(16'h50, 16'h31);
        c = $urandom_range(16'h7E, 16'h51);
        fmask = '0; fmask[a] = 1'b1; fmask[b] = 1'b1; fmask[c] = 1'b1;
        fmask[8'h90] = 1'b1; fmask[8'hF0] = 1'b1;
        dn = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (done0) dn++;
            if (k == 32) start = 1'b1;
            if (k == 33) start = 1'b0;
            if (k == 256) abort = 1'b1;
            if (k == 257) begin
                abort = 1'b0;
                chk("abort_busy", busy0, 1'b0);
            end
        end
        chk("abort_done_count", dn, STOP ? 1 : 0);
        chk("abort_err", err0, STOP ? 1 : 3);
        chk("abort_pass", pass0, 1'b0);
        chk("abort_ffv", {ffval0, ffv0}, {1'b1, 8'(a)});
        chk("abort_stays_idle", busy0, 1'b0);

        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        chk("abort_start_idle", {busy0, busy3}, 2'b00);
        chk("abort_start_err_held", err0, STOP ? 1 : 3);

        // reset mid-sweep at vector 0x40
        fmask = '0; fmask[8'h05] = 1'b1; fmask[8'h20] = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (128) @(negedge clk);
        chk("pre_rst_err", err0, STOP ? 1 : 2);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("rst_mid_outputs", {vec0, busy0, done0, pass0, err0, ffv0, ffval0}, 0);
        chk("rst_mid_outputs3", {vec3, busy3, done3, pass3, err3, ffv3, ffval3}, 0);

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
